// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: streams N elements into fsm_sort, runs start/done handshake, streams sorted result out.
// Optional SORT_CHECK_EN adds a sticky sort_err flag for out-of-order sorter results.
module sort_stream_ctrl #(
    parameter int N       = 6,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             sort_start,
    output logic [WIDTH-1:0] sort_data_in [N],
    input  logic             sort_done,
    input  logic [WIDTH-1:0] sort_data_sorted [N],
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
`ifdef SORT_CHECK_EN
    output logic             sort_err,
`endif
    output logic             timeout
);
    localparam int CW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] inbuf  [N];
    logic [WIDTH-1:0] outbuf [N];
    logic [CW-1:0]    wr_cnt, rd_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             armed;
    logic             wr_last, tmo_hit, capture;
    assign sort_data_in = inbuf;
    assign wr_last = wr_cnt == CW'(N - 1);
    assign tmo_hit = tmo_cnt == TW'(TIMEOUT - 1);
    // armed only after done has been seen low, so a done left over from the previous batch is ignored
    assign capture = armed && sort_done;
`ifdef SORT_CHECK_EN
    logic unsorted;
    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < N - 1; i++)
            unsorted = unsorted | (sort_data_sorted[i] > sort_data_sorted[i+1]);
    end
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            inbuf   <= '{default: '0};
            outbuf  <= '{default: '0};
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            tmo_cnt <= '0;
            armed   <= 1'b0;
            timeout <= 1'b0;
`ifdef SORT_CHECK_EN
            sort_err <= 1'b0;
`endif
        end else begin
            state <= nxt;
            case (state)
                LOAD: if (s_valid) begin
                    inbuf[wr_cnt] <= s_data;
                    wr_cnt        <= wr_last ? '0 : wr_cnt + 1'b1;
                end
                START: begin
                    armed   <= 1'b0;
                    tmo_cnt <= '0;
                end
                WAIT: if (capture) begin
                    outbuf <= sort_data_sorted;
`ifdef SORT_CHECK_EN
                    sort_err <= sort_err | unsorted;
`endif
                end else begin
                    armed   <= armed | ~sort_done;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    timeout <= timeout | tmo_hit;
                end
                DRAIN: if (m_ready) rd_cnt <= m_last ? '0 : rd_cnt + 1'b1;
                default: ;
            endcase
        end
    end
    always_comb begin
        nxt        = state;
        s_ready    = state == LOAD;
        sort_start = state == START;
        m_valid    = state == DRAIN;
        busy       = state != LOAD;
        m_data     = m_valid ? outbuf[rd_cnt] : '0;
        m_last     = m_valid && rd_cnt == CW'(N - 1);
        case (state)
            LOAD:    nxt = (s_valid && wr_last) ? START : LOAD;
            START:   nxt = WAIT;
            WAIT:    nxt = capture ? DRAIN : tmo_hit ? LOAD : WAIT;
            DRAIN:   nxt = (m_ready && m_last) ? LOAD : DRAIN;
            default: nxt = LOAD;
        endcase
    end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: directed bench for sort_stream_ctrl with a behavioural start/done sorter.
module tb_sort_stream_ctrl;
    localparam int N = 6;
    typedef logic [7:0] arr_t [N];
    logic clk = 0, rst = 0, s_valid = 0, m_ready = 0, sort_done = 0;
    logic s_ready, sort_start, m_valid, m_last, busy, timeout;
    logic [7:0] s_data = 0, m_data;
    arr_t sort_data_in, sorted;
    arr_t bad_arr = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6};
`ifdef SORT_CHECK_EN
    logic sort_err;
`endif
    int checks = 0, errors = 0, starts = 0, t = 0, fall_dly = 0, s0;
    bit pend = 0, dead = 0, bad = 0;

    sort_stream_ctrl #(.N(N), .WIDTH(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sort_start(sort_start), .sort_data_in(sort_data_in), .sort_done(sort_done),
        .sort_data_sorted(sorted), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .busy(busy),
`ifdef SORT_CHECK_EN
        .sort_err(sort_err),
`endif
        .timeout(timeout));

    always #5 clk = ~clk;

    function automatic arr_t sortf(arr_t a);
        arr_t r = a;
        logic [7:0] x;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (r[j] > r[j+1]) begin x = r[j]; r[j] = r[j+1]; r[j+1] = x; end
        return r;
    endfunction

    // done falls fall_dly edges after start (0 = on the start edge), rises 2N edges after that
    always @(posedge clk) begin
        if (sort_start) begin
            starts <= starts + 1;
            pend   <= 1;
            t      <= 1;
            if (fall_dly == 0) sort_done <= 0;
        end else if (pend) begin
            t <= t + 1;
            if (t == fall_dly) sort_done <= 0;
            if (!dead && t == fall_dly + 2 * N) begin
                sort_done <= 1;
                pend      <= 0;
                sorted    <= bad ? bad_arr : sortf(sort_data_in);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        int n = 0;
        s_valid = 1;
        s_data  = v;
        while (!s_ready) begin
            @(negedge clk);
            if (++n > 1000) begin chk("s_ready_wait", 0, 1); s_valid = 0; return; end
        end
        @(negedge clk);
        s_valid = 0;
    endtask

    task automatic push_batch(input arr_t a);
        for (int i = 0; i < N; i++) push(a[i]);
    endtask

    task automatic pop(input arr_t e, input bit tog, input int cnt);
        int n;
        for (int i = 0; i < cnt; i++) begin
            n = 0;
            forever begin
                m_ready = tog ? ~m_ready : 1'b1;
                if (m_valid && m_ready) break;
                if (m_valid) chk("hold_data", m_data, e[i]);
                @(negedge clk);
                if (++n > 200) begin chk("m_valid_wait", 0, 1); return; end
            end
            chk("m_data", m_data, e[i]);
            chk("m_last", m_last, i == N - 1);
            @(negedge clk);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_start", sort_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1;
        @(negedge clk);
        s0 = starts;
        push_batch('{8'd5, 8'd0, 8'd2, 8'd1, 8'd1, 8'd3});
        pop('{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5}, 0, N);
        chk("one_start", starts - s0, 1);
        idle_chk("b1_after");
        push_batch('{8'd3, 8'd2, 8'd4, 8'd0, 8'd1, 8'd5});
        pop('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1, N);
        idle_chk("b2_after");
        fall_dly = 3;
        push_batch('{8'd1, 8'd1, 8'd1, 8'd0, 8'd2, 8'd0});
        pop('{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2}, 0, N);
        fall_dly = 0;
        dead = 1;
        push_batch('{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7});
        repeat (255) @(negedge clk);
        chk("tmo_early", timeout, 0);
        chk("tmo_busy", busy, 1);
        @(negedge clk);
        chk("tmo_set", timeout, 1);
        idle_chk("tmo_after");
        dead = 0;
        push_batch('{8'd9, 8'd7, 8'd8, 8'd6, 8'd250, 8'd1});
        pop('{8'd1, 8'd6, 8'd7, 8'd8, 8'd9, 8'd250}, 0, 2);
        m_ready = 0;
        rst = 0;
        #1;
        idle_chk("mid_rst");
        chk("mid_rst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1;
        push_batch('{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9});
        pop('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9}, 0, N);
        idle_chk("b5_after");
`ifdef SORT_CHECK_EN
        bad = 1;
        push_batch('{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        pop(bad_arr, 0, N);
        chk("sort_err_set", sort_err, 1);
        rst = 0;
        @(negedge clk);
        rst = 1;
        bad = 0;
        chk("sort_err_rst", sort_err, 0);
        push_batch('{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        pop('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 0, N);
        chk("sort_err_clean", sort_err, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got 0 expected 1");
        $fatal(1, "watchdog");
    end
endmodule
